// File: rtl/ram_bus_arbiter.sv
// Byte-wide RAM/IO bus sequencer shared by the instruction fetcher and the load/store buffer.
// States: IDLE = arbitrate | READ = issue/capture read beats | WRITE = issue store beats | DONE = one-cycle done pulse
module ram_bus_arbiter #(
  parameter int         ID_WIDTH     = 4,
  parameter int         STARVE_LIMIT = 4,
  parameter logic [1:0] IO_PREFIX    = 2'b11
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rdy,
  input  logic                flush,
  input  logic                io_buffer_full,
  input  logic                fet_req,
  input  logic [31:0]         fet_addr,
  input  logic                lsb_req,
  input  logic                lsb_wr,
  input  logic [1:0]          lsb_size,
  input  logic                lsb_signed,
  input  logic [31:0]         lsb_addr,
  input  logic [31:0]         lsb_wdata,
  input  logic [ID_WIDTH-1:0] lsb_id,
  input  logic [7:0]          mem_din,
  output logic                fet_done,
  output logic [31:0]         fet_data,
  output logic [31:0]         fet_done_addr,
  output logic                lsb_done,
  output logic [31:0]         lsb_rdata,
  output logic [ID_WIDTH-1:0] lsb_done_id,
  output logic                busy,
  output logic [31:0]         mem_a,
  output logic [7:0]          mem_dout,
  output logic                mem_wr
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  function automatic logic is_io(input logic [31:0] a);
    return a[17:16] == IO_PREFIX;
  endfunction

  function automatic logic [2:0] beats(input logic [1:0] sz);
    case (sz)
      2'd0:    return 3'd1;
      2'd1:    return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  function automatic logic [31:0] extend(input logic [31:0] d, input logic [2:0] n,
                                         input logic sgn);
    case (n)
      3'd1:    return {{24{sgn & d[7]}}, d[7:0]};
      3'd2:    return {{16{sgn & d[15]}}, d[15:0]};
      default: return d;
    endcase
  endfunction

  state_t              state_q, state_d;
  logic [SW-1:0]       starve_q, starve_d;
  logic [2:0]          cnt_q, cnt_d;
  logic [2:0]          n_q, n_d;
  logic                is_fet_q, is_fet_d;
  logic                signed_q, signed_d;
  logic [31:0]         addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [ID_WIDTH-1:0] id_q, id_d;
  logic [31:0]         buf_q, buf_d;
  logic [31:0]         mem_a_q, mem_a_d;
  logic [7:0]          mem_dout_q, mem_dout_d;
  logic                wr_q, wr_d;
  logic                fet_done_q, fet_done_d;
  logic [31:0]         fet_data_q, fet_data_d;
  logic [31:0]         fet_done_addr_q, fet_done_addr_d;
  logic                lsb_done_q, lsb_done_d;
  logic [31:0]         lsb_rdata_q, lsb_rdata_d;
  logic [ID_WIDTH-1:0] lsb_done_id_q, lsb_done_id_d;
  logic                busy_q, busy_d;

  logic        starve_hit;
  logic        grant_lsb;
  logic [31:0] beat_addr;
  logic [31:0] next_addr;
  logic [2:0]  cap_idx;

  assign starve_hit = starve_q == SW'(STARVE_LIMIT);
  assign grant_lsb  = lsb_req && !(fet_req && starve_hit);
  assign beat_addr  = addr_q + {29'd0, cnt_q};
  assign next_addr  = beat_addr + 32'd1;
  // cnt_q counts addresses already put on the bus; mem_din holds the previous one
  assign cap_idx    = cnt_q - 3'd1;

  always_comb begin
    state_d         = state_q;
    starve_d        = starve_q;
    cnt_d           = cnt_q;
    n_d             = n_q;
    is_fet_d        = is_fet_q;
    signed_d        = signed_q;
    addr_d          = addr_q;
    wdata_d         = wdata_q;
    id_d            = id_q;
    buf_d           = buf_q;
    mem_a_d         = 32'd0;
    mem_dout_d      = 8'd0;
    wr_d            = 1'b0;
    fet_done_d      = 1'b0;
    fet_data_d      = fet_data_q;
    fet_done_addr_d = fet_done_addr_q;
    lsb_done_d      = 1'b0;
    lsb_rdata_d     = lsb_rdata_q;
    lsb_done_id_d   = lsb_done_id_q;

    case (state_q)
      IDLE: begin
        if (!flush && (lsb_req || fet_req)) begin
          cnt_d = 3'd0;
          buf_d = 32'd0;
          if (grant_lsb) begin
            if (fet_req) starve_d = starve_q + SW'(1);
            is_fet_d = 1'b0;
            addr_d   = lsb_addr;
            n_d      = beats(lsb_size);
            signed_d = lsb_signed;
            wdata_d  = lsb_wdata;
            id_d     = lsb_id;
            if (lsb_wr) begin
              state_d = WRITE;
              if (!(is_io(lsb_addr) && io_buffer_full)) begin
                wr_d       = 1'b1;
                mem_a_d    = lsb_addr;
                mem_dout_d = lsb_wdata[7:0];
                cnt_d      = 3'd1;
              end
            end else begin
              state_d = READ;
              mem_a_d = lsb_addr;
            end
          end else begin
            starve_d = '0;
            is_fet_d = 1'b1;
            addr_d   = fet_addr;
            n_d      = 3'd4;
            signed_d = 1'b0;
            state_d  = READ;
            mem_a_d  = fet_addr;
          end
        end
      end

      READ: begin
        if (flush) begin
          state_d = IDLE;
        end else begin
          if (cnt_q != 3'd0) buf_d[{cap_idx[1:0], 3'b000} +: 8] = mem_din;
          if (cnt_q == n_q) begin
            state_d = DONE;
            if (is_fet_q) begin
              fet_done_d      = 1'b1;
              fet_data_d      = buf_d;
              fet_done_addr_d = addr_q;
            end else begin
              lsb_done_d    = 1'b1;
              lsb_rdata_d   = extend(buf_d, n_q, signed_q);
              lsb_done_id_d = id_q;
            end
          end else begin
            cnt_d = cnt_q + 3'd1;
            if (cnt_q + 3'd1 < n_q) mem_a_d = next_addr;
          end
        end
      end

      WRITE: begin
        // Stores are already committed, so flush is deliberately not looked at here
        if (cnt_q == n_q) begin
          state_d       = DONE;
          lsb_done_d    = 1'b1;
          lsb_rdata_d   = 32'd0;
          lsb_done_id_d = id_q;
        end else if (!(is_io(beat_addr) && io_buffer_full)) begin
          wr_d       = 1'b1;
          mem_a_d    = beat_addr;
          mem_dout_d = wdata_q[{cnt_q[1:0], 3'b000} +: 8];
          cnt_d      = cnt_q + 3'd1;
        end
      end

      default: state_d = IDLE;
    endcase

    busy_d = state_d != IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      starve_q        <= '0;
      cnt_q           <= 3'd0;
      n_q             <= 3'd0;
      is_fet_q        <= 1'b0;
      signed_q        <= 1'b0;
      addr_q          <= 32'd0;
      wdata_q         <= 32'd0;
      id_q            <= '0;
      buf_q           <= 32'd0;
      mem_a_q         <= 32'd0;
      mem_dout_q      <= 8'd0;
      wr_q            <= 1'b0;
      fet_done_q      <= 1'b0;
      fet_data_q      <= 32'd0;
      fet_done_addr_q <= 32'd0;
      lsb_done_q      <= 1'b0;
      lsb_rdata_q     <= 32'd0;
      lsb_done_id_q   <= '0;
      busy_q          <= 1'b0;
    end else if (rdy) begin
      state_q         <= state_d;
      starve_q        <= starve_d;
      cnt_q           <= cnt_d;
      n_q             <= n_d;
      is_fet_q        <= is_fet_d;
      signed_q        <= signed_d;
      addr_q          <= addr_d;
      wdata_q         <= wdata_d;
      id_q            <= id_d;
      buf_q           <= buf_d;
      mem_a_q         <= mem_a_d;
      mem_dout_q      <= mem_dout_d;
      wr_q            <= wr_d;
      fet_done_q      <= fet_done_d;
      fet_data_q      <= fet_data_d;
      fet_done_addr_q <= fet_done_addr_d;
      lsb_done_q      <= lsb_done_d;
      lsb_rdata_q     <= lsb_rdata_d;
      lsb_done_id_q   <= lsb_done_id_d;
      busy_q          <= busy_d;
    end
  end

  assign fet_done      = fet_done_q;
  assign fet_data      = fet_data_q;
  assign fet_done_addr = fet_done_addr_q;
  assign lsb_done      = lsb_done_q;
  assign lsb_rdata     = lsb_rdata_q;
  assign lsb_done_id   = lsb_done_id_q;
  assign busy          = busy_q;
  assign mem_a         = mem_a_q;
  assign mem_dout      = mem_dout_q;
  assign mem_wr        = wr_q & rdy;

endmodule

// File: tb/tb_ram_bus_arbiter.sv
// Directed bench for ram_bus_arbiter with a synchronous byte RAM model behind the bus.
module tb_ram_bus_arbiter;
  localparam int IDW = 4;

  logic           clk = 1'b0;
  logic           rst, rdy, flush, io_buffer_full;
  logic           fet_req;
  logic [31:0]    fet_addr;
  logic           lsb_req, lsb_wr, lsb_signed;
  logic [1:0]     lsb_size;
  logic [31:0]    lsb_addr, lsb_wdata;
  logic [IDW-1:0] lsb_id;
  logic [7:0]     mem_din;
  logic           fet_done, lsb_done, busy, mem_wr;
  logic [31:0]    fet_data, fet_done_addr, lsb_rdata, mem_a;
  logic [IDW-1:0] lsb_done_id;
  logic [7:0]     mem_dout;

  logic [7:0]  ram [0:262143];
  logic        poke_en;
  logic [17:0] poke_a;
  logic [7:0]  poke_d;

  int tests_run = 0;
  int failed    = 0;

  always #5 clk = ~clk;

  ram_bus_arbiter #(.ID_WIDTH(IDW), .STARVE_LIMIT(4), .IO_PREFIX(2'b11)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush), .io_buffer_full(io_buffer_full),
    .fet_req(fet_req), .fet_addr(fet_addr),
    .lsb_req(lsb_req), .lsb_wr(lsb_wr), .lsb_size(lsb_size), .lsb_signed(lsb_signed),
    .lsb_addr(lsb_addr), .lsb_wdata(lsb_wdata), .lsb_id(lsb_id), .mem_din(mem_din),
    .fet_done(fet_done), .fet_data(fet_data), .fet_done_addr(fet_done_addr),
    .lsb_done(lsb_done), .lsb_rdata(lsb_rdata), .lsb_done_id(lsb_done_id),
    .busy(busy), .mem_a(mem_a), .mem_dout(mem_dout), .mem_wr(mem_wr)
  );

  // Synchronous RAM: read data appears the cycle after the address; holds while rdy is low
  always @(posedge clk) begin
    if (poke_en) ram[poke_a] <= poke_d;
    else if (mem_wr) ram[mem_a[17:0]] <= mem_dout;
    if (rdy) mem_din <= ram[mem_a[17:0]];
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic poke(input logic [17:0] a, input logic [7:0] d);
    poke_a = a; poke_d = d; poke_en = 1'b1;
    step();
    poke_en = 1'b0;
  endtask

  task automatic idle_inputs();
    fet_req = 0; lsb_req = 0; flush = 0; io_buffer_full = 0; rdy = 1;
    lsb_wr = 0; lsb_size = 0; lsb_signed = 0; lsb_addr = 0; lsb_wdata = 0; lsb_id = 0;
    fet_addr = 0;
  endtask

  task automatic set_lsb(input logic wr, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] wd, input logic [IDW-1:0] id);
    lsb_wr = wr; lsb_size = sz; lsb_signed = sg; lsb_addr = a; lsb_wdata = wd; lsb_id = id;
    lsb_req = 1'b1;
  endtask

  task automatic test_reset();
    logic [31:0] or_all;
    or_all = {31'd0, fet_done} | {31'd0, lsb_done} | {31'd0, busy} | {31'd0, mem_wr} |
             mem_a | {24'd0, mem_dout} | fet_data | fet_done_addr | lsb_rdata |
             {28'd0, lsb_done_id};
    tests_run++;
    if (or_all !== 32'd0) begin
      failed++; $display("FAIL reset_outputs got %h expected 0", or_all);
    end
    rst = 0;
    set_lsb(1, 2, 0, 32'h600, 32'hCAFEF00D, 4'd1);
    step();
    tests_run++;
    if (mem_wr !== 1'b1) begin failed++; $display("FAIL rst_mid_wr_c1 got %b expected 1", mem_wr); end
    step();
    rst = 1; lsb_req = 0;
    step();
    rst = 0;
    tests_run++;
    if ({mem_wr, busy, lsb_done} !== 3'b000) begin
      failed++; $display("FAIL rst_mid_state got %b expected 000", {mem_wr, busy, lsb_done});
    end
    step();
    tests_run++;
    if ({busy, lsb_done} !== 2'b00) begin
      failed++; $display("FAIL rst_mid_after got %b expected 00", {busy, lsb_done});
    end
  endtask

  task automatic test_fetch();
    logic [31:0] exp_a;
    fet_addr = 32'h100; fet_req = 1;
    for (int c = 1; c <= 7; c++) begin
      step();
      exp_a = (c >= 1 && c <= 4) ? 32'(32'h100 + c - 1) : 32'd0;
      tests_run++;
      if (mem_a !== exp_a) begin failed++; $display("FAIL fetch_mem_a c%0d got %h expected %h", c, mem_a, exp_a); end
      tests_run++;
      if (fet_done !== (c == 6)) begin failed++; $display("FAIL fetch_done c%0d got %b", c, fet_done); end
      if (c == 6) begin
        tests_run++;
        if (fet_data !== 32'h00000513) begin failed++; $display("FAIL fetch_data got %h expected 00000513", fet_data); end
        tests_run++;
        if (fet_done_addr !== 32'h100) begin failed++; $display("FAIL fetch_addr got %h expected 100", fet_done_addr); end
        fet_req = 0;
      end
      if (c == 7) begin
        tests_run++;
        if (busy !== 1'b0) begin failed++; $display("FAIL fetch_busy_c7 got %b expected 0", busy); end
      end
    end
  endtask

  task automatic test_load(input string nm, input logic [31:0] a, input logic [1:0] sz,
                           input logic sg, input logic [IDW-1:0] id,
                           input logic [31:0] exp, input int done_c);
    set_lsb(0, sz, sg, a, 32'd0, id);
    for (int c = 1; c <= done_c + 1; c++) begin
      step();
      tests_run++;
      if (lsb_done !== (c == done_c)) begin failed++; $display("FAIL %s_done c%0d got %b", nm, c, lsb_done); end
      if (c == done_c) begin
        tests_run++;
        if (lsb_rdata !== exp) begin failed++; $display("FAIL %s_rdata got %h expected %h", nm, lsb_rdata, exp); end
        tests_run++;
        if (lsb_done_id !== id) begin failed++; $display("FAIL %s_id got %0d expected %0d", nm, lsb_done_id, id); end
        lsb_req = 0;
      end
    end
    tests_run++;
    if (busy !== 1'b0) begin failed++; $display("FAIL %s_idle got busy %b expected 0", nm, busy); end
  endtask

  task automatic test_half_store();
    set_lsb(1, 1, 0, 32'h1FFFF, 32'h1234BEEF, 4'd9);
    step();
    tests_run++;
    if ({mem_wr, mem_a, mem_dout} !== {1'b1, 32'h1FFFF, 8'hEF}) begin
      failed++; $display("FAIL hstore_beat0 got %b %h %h expected 1 1ffff ef", mem_wr, mem_a, mem_dout);
    end
    step();
    tests_run++;
    if ({mem_wr, mem_a, mem_dout} !== {1'b1, 32'h20000, 8'hBE}) begin
      failed++; $display("FAIL hstore_beat1 got %b %h %h expected 1 20000 be", mem_wr, mem_a, mem_dout);
    end
    step();
    tests_run++;
    if ({lsb_done, mem_wr, lsb_rdata, lsb_done_id} !== {2'b10, 32'd0, 4'd9}) begin
      failed++; $display("FAIL hstore_done got %b %b %h %0d expected 1 0 0 9", lsb_done, mem_wr, lsb_rdata, lsb_done_id);
    end
    lsb_req = 0;
    step();
    test_load("hstore_readback", 32'h1FFFF, 1, 0, 4'd2, 32'h0000BEEF, 4);
  endtask

  task automatic test_io_stall();
    int writes = 0;
    io_buffer_full = 1;
    set_lsb(1, 0, 0, 32'h30000, 32'h000000A5, 4'd4);
    for (int c = 1; c <= 6; c++) begin
      step();
      io_buffer_full = (c < 3);
      if (mem_wr === 1'b1) writes++;
      tests_run++;
      if (mem_wr !== (c == 4)) begin failed++; $display("FAIL io_wr c%0d got %b", c, mem_wr); end
      if (c <= 3) begin
        tests_run++;
        if (mem_a !== 32'd0) begin failed++; $display("FAIL io_stall_a c%0d got %h expected 0", c, mem_a); end
      end
      if (c == 4) begin
        tests_run++;
        if ({mem_a, mem_dout} !== {32'h30000, 8'hA5}) begin
          failed++; $display("FAIL io_beat got %h %h expected 30000 a5", mem_a, mem_dout);
        end
      end
      tests_run++;
      if (lsb_done !== (c == 5)) begin failed++; $display("FAIL io_done c%0d got %b", c, lsb_done); end
      if (c == 5) lsb_req = 0;
    end
    tests_run++;
    if (writes != 1) begin failed++; $display("FAIL io_write_count got %0d expected 1", writes); end
  endtask

  task automatic test_starvation();
    int n = 0;
    logic [9:0] got;
    logic [9:0] exp;
    exp = 10'b10000_10000;
    got = '0;
    rst = 1; step(); rst = 0;
    fet_addr = 32'h100; fet_req = 1;
    set_lsb(0, 0, 0, 32'h204, 32'd0, 4'd3);
    for (int c = 0; c < 200 && n < 10; c++) begin
      step();
      if (fet_done && lsb_done) begin
        tests_run++; failed++; $display("FAIL starve_both_done c%0d got 11 expected one", c);
      end
      if (fet_done || lsb_done) begin
        got[n] = fet_done;
        n++;
      end
    end
    fet_req = 0; lsb_req = 0;
    tests_run++;
    if (n != 10) begin failed++; $display("FAIL starve_count got %0d expected 10", n); end
    for (int i = 0; i < n; i++) begin
      tests_run++;
      if (got[i] !== exp[i]) begin failed++; $display("FAIL starve_order grant%0d got fet=%b expected fet=%b", i, got[i], exp[i]); end
    end
    for (int c = 0; c < 20 && busy; c++) step();
    step();
  endtask

  task automatic test_flush_read();
    logic [31:0] exp_a [1:3];
    exp_a[1] = 32'h500; exp_a[2] = 32'h501; exp_a[3] = 32'h502;
    set_lsb(0, 2, 0, 32'h500, 32'd0, 4'd6);
    for (int c = 1; c <= 8; c++) begin
      step();
      if (c <= 3) begin
        tests_run++;
        if (mem_a !== exp_a[c]) begin failed++; $display("FAIL flrd_a c%0d got %h expected %h", c, mem_a, exp_a[c]); end
      end
      if (c == 3) begin flush = 1; lsb_req = 0; end
      if (c == 4) begin
        flush = 0;
        tests_run++;
        if ({busy, mem_a} !== 33'd0) begin failed++; $display("FAIL flrd_idle got busy %b a %h expected 0 0", busy, mem_a); end
      end
      tests_run++;
      if (lsb_done !== 1'b0) begin failed++; $display("FAIL flrd_done c%0d got %b expected 0", c, lsb_done); end
    end
    // flush while idle with a pending request blocks that cycle's grant
    flush = 1;
    set_lsb(0, 0, 0, 32'h204, 32'd0, 4'd7);
    step();
    flush = 0;
    tests_run++;
    if (busy !== 1'b0) begin failed++; $display("FAIL flidle_nogrant got busy %b expected 0", busy); end
    step();
    tests_run++;
    if ({busy, mem_a} !== {1'b1, 32'h204}) begin failed++; $display("FAIL flidle_grant got %b %h expected 1 204", busy, mem_a); end
    step();
    step();
    tests_run++;
    if ({lsb_done, lsb_rdata} !== {1'b1, 32'h80}) begin
      failed++; $display("FAIL flidle_done got %b %h expected 1 00000080", lsb_done, lsb_rdata);
    end
    lsb_req = 0;
    step();
  endtask

  task automatic test_flush_write();
    logic [7:0] exp_b [1:4];
    exp_b[1] = 8'h44; exp_b[2] = 8'h33; exp_b[3] = 8'h22; exp_b[4] = 8'h11;
    set_lsb(1, 2, 0, 32'h640, 32'h11223344, 4'd8);
    for (int c = 1; c <= 6; c++) begin
      step();
      flush = (c == 2);
      if (c <= 4) begin
        tests_run++;
        if ({mem_wr, mem_a, mem_dout} !== {1'b1, 32'(32'h640 + c - 1), exp_b[c]}) begin
          failed++; $display("FAIL flwr_beat c%0d got %b %h %h expected 1 %h %h", c, mem_wr, mem_a, mem_dout, 32'h640 + c - 1, exp_b[c]);
        end
      end
      tests_run++;
      if (lsb_done !== (c == 5)) begin failed++; $display("FAIL flwr_done c%0d got %b", c, lsb_done); end
      if (c == 5) lsb_req = 0;
    end
    test_load("flwr_readback", 32'h640, 2, 0, 4'd8, 32'h11223344, 6);
  endtask

  task automatic test_rdy_stall();
    logic [31:0] exp_a [1:7];
    exp_a[1] = 32'h500; exp_a[2] = 32'h501; exp_a[3] = 32'h501; exp_a[4] = 32'h501;
    exp_a[5] = 32'h502; exp_a[6] = 32'h503; exp_a[7] = 32'h0;
    set_lsb(0, 2, 0, 32'h500, 32'd0, 4'd10);
    for (int c = 1; c <= 9; c++) begin
      step();
      rdy = !(c == 2 || c == 3);
      if (c <= 7) begin
        tests_run++;
        if (mem_a !== exp_a[c]) begin failed++; $display("FAIL rdy_a c%0d got %h expected %h", c, mem_a, exp_a[c]); end
      end
      tests_run++;
      if (lsb_done !== (c == 8)) begin failed++; $display("FAIL rdy_done c%0d got %b", c, lsb_done); end
      if (c == 8) begin
        tests_run++;
        if (lsb_rdata !== 32'hEFBEADDE) begin failed++; $display("FAIL rdy_data got %h expected efbeadde", lsb_rdata); end
        lsb_req = 0;
      end
    end
    rdy = 1;
    // mem_wr is gated by rdy even while a beat is pending
    set_lsb(1, 0, 0, 32'h700, 32'h5A, 4'd11);
    step();
    rdy = 0; #1;
    tests_run++;
    if (mem_wr !== 1'b0) begin failed++; $display("FAIL rdy_wr_gate got %b expected 0", mem_wr); end
    step();
    rdy = 1; #1;
    tests_run++;
    if ({mem_wr, mem_a, mem_dout} !== {1'b1, 32'h700, 8'h5A}) begin
      failed++; $display("FAIL rdy_wr_beat got %b %h %h expected 1 700 5a", mem_wr, mem_a, mem_dout);
    end
    step();
    tests_run++;
    if (lsb_done !== 1'b1) begin failed++; $display("FAIL rdy_wr_done got %b expected 1", lsb_done); end
    lsb_req = 0;
    step();
    test_load("rdy_wr_readback", 32'h700, 0, 0, 4'd12, 32'h0000005A, 3);
  endtask

  initial begin
    rst = 1; poke_en = 0; poke_a = 0; poke_d = 0;
    idle_inputs();
    poke(18'h100, 8'h13); poke(18'h101, 8'h05); poke(18'h102, 8'h00); poke(18'h103, 8'h00);
    poke(18'h204, 8'h80);
    poke(18'h300, 8'h34); poke(18'h301, 8'h92);
    poke(18'h500, 8'hDE); poke(18'h501, 8'hAD); poke(18'h502, 8'hBE); poke(18'h503, 8'hEF);
    test_reset();
    test_fetch();
    test_load("lb_signed",   32'h204, 0, 1, 4'd5, 32'hFFFFFF80, 3);
    test_load("lb_unsigned", 32'h204, 0, 0, 4'd6, 32'h00000080, 3);
    test_load("lh_signed",   32'h300, 1, 1, 4'd2, 32'hFFFF9234, 4);
    test_load("lh_unsigned", 32'h300, 1, 0, 4'd3, 32'h00009234, 4);
    test_load("lw",          32'h500, 2, 0, 4'd7, 32'hEFBEADDE, 6);
    test_load("lsize3",      32'h500, 3, 1, 4'd1, 32'hEFBEADDE, 6);
    test_half_store();
    test_io_stall();
    test_starvation();
    test_flush_read();
    test_flush_write();
    test_rdy_stall();
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule
